// File: rtl/conv_pkg.sv
// Shared types and constants for the 5-row convolution line-buffer controller.
package conv_pkg;

    localparam int IMAGE_MAX_W = 64;
    localparam int PIXEL_W     = 8;
    localparam int LB_N        = 4;
    localparam int ADDR_W      = $clog2(IMAGE_MAX_W);
    localparam int ROW_W       = 3;

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMAGE_MAX_W - 1);
    localparam logic [ROW_W-1:0]  ROWS_MAX = ROW_W'(LB_N);

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_FILL   = 2'd2,
        ST_STEADY = 2'd3
    } state_t;

endpackage

// File: rtl/conv_lbx_dly.sv
// Valid-qualified delay line. Valid bits are reset so a reset drops anything
// in flight; data flops only load behind a valid and carry no reset.
module conv_lbx_dly #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    // Valid shift chain.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data shift chain, each stage enabled by the valid of the stage feeding it.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            dat_q[0] <= in_dat;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (vld_q[i-1]) begin
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_dat = dat_q[DEPTH-1];

endmodule

// File: rtl/conv_lbx_ctrl.sv
// Line-buffer controller for a 5-row convolution window.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start of frame; pixels without sof are dropped
//   ST_FIRST  | first line of frame, measuring the line width
//   ST_FILL   | line buffers still filling (1..3 lines stored)
//   ST_STEADY | all four line buffers hold a full line; full columns out
//
// A pixel flagged with sof always restarts the frame, whatever the state, and
// is itself treated as column 0 of line 1 (so it pops nothing).
module conv_lbx_ctrl
    import conv_pkg::*;
#(
    parameter int LB_LAT = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_vld_i,
    input  pixel_t            in_dat_i,
    input  logic              in_sof_i,
    input  logic              in_eol_i,
    output logic [4:1]        lb_push_o,
    output logic [4:1]        lb_pop_o,
    output pixel_t            lb_dat_o,
    output logic              lb_sof_o,
    output logic              lb_eol_o,
    input  pixel_t [4:1]      lb_col_i,
    output logic              col_vld_o,
    output pixel_t [4:0]      col_dat_o,
    output logic              col_sof_o,
    output logic              col_eol_o,
    output logic              col_full_o,
    output logic              err_o
);

    localparam int DLY_W = PIXEL_W + 2 + LB_N;

    state_t              state_q, state_d, cur_state;
    logic [ADDR_W-1:0]   col_q, col_d, cur_col;
    logic [ROW_W-1:0]    rows_q, rows_d, cur_rows;
    logic [ADDR_W:0]     width_q, width_d, cur_width;
    logic                err_q, err_d;
    logic                accept, at_end, eol_eff;

    logic                dly_vld;
    logic [DLY_W-1:0]    dly_in, dly_out;
    pixel_t              d_pix;
    logic                d_sof, d_eol;
    logic [4:1]          d_pop;

    // State, counters, latched width and sticky error.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            rows_q  <= '0;
            width_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            width_q <= width_d;
            err_q   <= err_d;
        end
    end

    // Next-state: sof overrides the frame context before the line rules run.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        rows_d    = rows_q;
        width_d   = width_q;
        err_d     = err_q;
        cur_state = state_q;
        cur_col   = col_q;
        cur_rows  = rows_q;
        cur_width = width_q;
        at_end    = 1'b0;
        eol_eff   = 1'b0;
        accept    = in_vld_i && (in_sof_i || (state_q != ST_IDLE));

        if (in_vld_i && in_sof_i) begin
            cur_state = ST_FIRST;
            cur_col   = '0;
            cur_rows  = '0;
            cur_width = '0;
        end

        if (accept) begin
            state_d = cur_state;
            rows_d  = cur_rows;
            width_d = cur_width;
            case (cur_state)
                ST_FIRST: begin
                    // A line that runs to the buffer depth is cut there.
                    at_end  = (cur_col == COL_LAST);
                    eol_eff = in_eol_i || at_end;
                    if (at_end && !in_eol_i) begin
                        err_d = 1'b1;
                    end
                    if (eol_eff) begin
                        width_d = {1'b0, cur_col} + 1'b1;
                        rows_d  = ROW_W'(1);
                        state_d = ST_FILL;
                    end
                end
                ST_FILL, ST_STEADY: begin
                    // Early or missing eol both flag an error; the line still
                    // ends so the buffers stay column-aligned.
                    at_end  = ({1'b0, cur_col} == (cur_width - 1'b1));
                    eol_eff = in_eol_i || at_end;
                    if (in_eol_i != at_end) begin
                        err_d = 1'b1;
                    end
                    if (eol_eff) begin
                        if (cur_rows >= (ROWS_MAX - 1'b1)) begin
                            rows_d  = ROWS_MAX;
                            state_d = ST_STEADY;
                        end else begin
                            rows_d  = cur_rows + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            col_d = eol_eff ? '0 : (cur_col + 1'b1);
        end
    end

    // Line-buffer write/read strobes; buffer i is read once it holds a line.
    always_comb begin
        lb_push_o = {LB_N{accept}};
        lb_pop_o  = '0;
        for (int i = 1; i <= LB_N; i++) begin
            lb_pop_o[i] = accept && (cur_rows >= ROW_W'(i));
        end
    end

    assign lb_dat_o = in_dat_i;
    assign lb_sof_o = in_sof_i;
    assign lb_eol_o = in_eol_i;
    assign err_o    = err_q;

    assign dly_in = {in_dat_i, in_sof_i, in_eol_i, lb_pop_o};

    conv_lbx_dly #(
        .DEPTH (LB_LAT),
        .WIDTH (DLY_W)
    ) u_dly (
        .clk     (clk),
        .arst_n  (arst_n),
        .in_vld  (accept),
        .in_dat  (dly_in),
        .out_vld (dly_vld),
        .out_dat (dly_out)
    );

    assign {d_pix, d_sof, d_eol, d_pop} = dly_out;

    // Assemble the aligned column; everything is zero when no entry emerges.
    always_comb begin
        col_vld_o  = dly_vld;
        col_dat_o  = '0;
        col_sof_o  = 1'b0;
        col_eol_o  = 1'b0;
        col_full_o = 1'b0;
        if (dly_vld) begin
            col_dat_o[0] = d_pix;
            for (int i = 1; i <= LB_N; i++) begin
                if (d_pop[i]) begin
                    col_dat_o[i] = lb_col_i[i];
                end
            end
            col_sof_o  = d_sof;
            col_eol_o  = d_eol;
            col_full_o = (d_pop == 4'b1111);
        end
    end

endmodule

// File: doc/conv_lbx_ctrl.md
CONV_LBX_CTRL -- requirements
Module: conv_lbx_ctrl

Interface
REQ-001 SHALL have parameter LB_LAT, default 2, line-buffer read latency in cycles (BRAM read plus output flop).
REQ-002 SHALL have port clk  input  1  sole clock; all state is rising-edge.
REQ-003 SHALL have port arst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_vld_i  input  1  pixel valid; push-only stream, no backpressure.
REQ-005 SHALL have port in_dat_i  input  conv_pkg::pixel_t  input pixel.
REQ-006 SHALL have port in_sof_i  input  1  first pixel of frame, qualified by in_vld_i.
REQ-007 SHALL have port in_eol_i  input  1  last pixel of line, qualified by in_vld_i.
REQ-008 SHALL have ports lb_push_o, lb_pop_o  output  4  per-line-buffer push/pop, index 4:1.
REQ-009 SHALL have ports lb_dat_o (pixel_t), lb_sof_o, lb_eol_o  output  line-buffer write data and sideband.
REQ-010 SHALL have port lb_col_i  input  conv_pkg::pixel_t [4:1]  line-buffer column, LB_LAT after pop.
REQ-011 SHALL have ports col_vld_o (1), col_dat_o (pixel_t [4:0]), col_sof_o, col_eol_o, col_full_o  output  aligned 5-row column; col_full_o = all 5 rows valid.
REQ-012 SHALL have port err_o  output  1  sticky line-length error.

Function
REQ-013 SHALL implement FSM IDLE, FIRST, FILL, STEADY; reset state IDLE.
REQ-014 IDLE: valid pixels without in_sof_i dropped (no push); in_vld_i&in_sof_i -> FIRST.
REQ-015 FIRST: column counter counts accepted pixels; on in_eol_i latch width = col+1, row count = 1 -> FILL.
REQ-016 FILL: each in_eol_i increments row count; row count reaching 4 -> STEADY; row count saturates at 4.
REQ-017 In any state, in_vld_i&in_sof_i SHALL restart frame: column 0, row count 0, width cleared, state FIRST, err_o unchanged.
REQ-018 lb_push_o SHALL be combinational: {4{in_vld_i accepted}}; lb_dat_o/lb_sof_o/lb_eol_o pass through in_dat_i/in_sof_i/in_eol_i same cycle.
REQ-019 lb_pop_o[i] SHALL equal lb_push_o[i] & (row count >= i), row count as registered before the pixel.
REQ-020 Column counter SHALL reset to 0 after in_eol_i and on sof; width ADDR_W = $clog2(IMAGE_MAX_W).
REQ-021 In FILL/STEADY, in_eol_i at column != width-1, or column == width-1 without in_eol_i, SHALL set err_o and treat the pixel as end-of-line.
REQ-022 In FIRST, column reaching IMAGE_MAX_W-1 without in_eol_i SHALL set err_o and force end-of-line.
REQ-023 Accepted pixel, sof, eol, pop mask SHALL be delayed LB_LAT cycles through a valid-qualified pipe; col_vld_o asserts exactly LB_LAT cycles after acceptance.
REQ-024 col_dat_o[0] = delayed current pixel; col_dat_o[i] = lb_col_i[i] when delayed pop mask bit i set, else 0.
REQ-025 col_full_o SHALL equal delayed pop mask == 4'b1111.
REQ-026 Back-to-back pixels every cycle SHALL sustain full throughput, no bubbles.

Reset
REQ-027 On arst_n low: state IDLE, counters 0, width 0, pipe valids 0, err_o 0, col_vld_o/col_sof_o/col_eol_o/col_full_o 0, col_dat_o 0.
REQ-028 Reset mid-frame SHALL discard in-flight pipe entries; no col_vld_o until after a new sof plus LB_LAT.
REQ-029 Data-only pipe flops MAY be non-reset; valid, control and output flops SHALL be reset.

Structure
REQ-030 IMAGE_MAX_W, PIXEL_W, pixel_t, LB_N=4 and FSM state enum SHALL live in conv_pkg.
REQ-031 Delay pipe SHALL be one sub-module conv_lbx_dly (parameterised depth/width, valid-qualified).
REQ-032 SHALL use the common flop macros; no latches.

Verification
REQ-033 Width-8 frame, 6 lines, continuous valid -> lb_pop_o 0000, 0001, 0011, 0111 on lines 1-4, 1111 lines 5-6; col_full_o first on line 5 pixel 0.
REQ-034 Single pixel 0x5A sof at cycle T -> col_vld_o and col_dat_o[0]=0x5A at T+2, col_sof_o=1.
REQ-035 Line 3 eol at column 5 with width 8 -> err_o=1 from next cycle, row count advances, column resets to 0.
REQ-036 sof mid-line 3 -> FIRST entered, lb_pop_o 0000 for new line 1, err_o unchanged.
REQ-037 Pixels without sof after reset -> no lb_push_o, no col_vld_o.
REQ-038 arst_n pulse with two pixels in pipe -> col_vld_o stays 0, all outputs 0 during and after reset.
